// File: rtl/input_debounce_sync.sv
// Two-channel synchronizer + debouncer producing clean a/b levels and rise pulses.
// Define DEBOUNCE_RISE_EN to build the a_rise/b_rise pulse registers; otherwise they are tied 0.
//
// state   | meaning
// STABLE  | synchronized input equals debounced level, counter held at 0
// PENDING | synchronized input disagrees, counting toward terminal count
module input_debounce_sync #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_PENDING} state_e;

  logic [1:0] lvl;
  logic [1:0] rise;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             raw_ch;
    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state;

    assign raw_ch = (ch == 0) ? a_raw : b_raw;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= raw_ch;
        s2_q  <= s1_q;
        lvl_q <= lvl_d;
        cnt_q <= cnt_d;
      end
    end

    // Any agreement with the held level clears the count: no partial credit.
    always_comb begin
      state = ST_STABLE;
      lvl_d = lvl_q;
      cnt_d = '0;
      if (s2_q != lvl_q) state = ST_PENDING;
      if (state == ST_PENDING) begin
        if (cnt_q == TC) begin
          lvl_d = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

`ifdef DEBOUNCE_RISE_EN
    logic rise_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rise_q <= 1'b0;
      else     rise_q <= lvl_d & ~lvl_q;
    end

    assign rise[ch] = rise_q;
`else
    assign rise[ch] = 1'b0;
`endif

    assign lvl[ch] = lvl_q;
  end

  assign a      = lvl[0];
  assign b      = lvl[1];
  assign a_rise = rise[0];
  assign b_rise = rise[1];

endmodule

// File: doc/input_debounce_sync.md
# input_debounce_sync

Two-channel synchronizer and debouncer for raw, asynchronous switch/button inputs. It sits directly upstream of the two-input dataflow gate stages and produces the clean, glitch-free `a` and `b` operands those stages consume. It also produces optional single-cycle rising-edge pulses for event-driven logic.

## Interface

- `STABLE_CYCLES`, default 16: consecutive synchronized cycles an input must hold a new level before the output follows it; legal range ≥ 1.
- `CNT_W`, default `$clog2(STABLE_CYCLES)` (minimum 1): counter width; derived, never overridden.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `a_raw` input 1: raw, asynchronous channel A input.
- `b_raw` input 1: raw, asynchronous channel B input.
- `a` output 1: debounced channel A level; feeds gate input `a`.
- `b` output 1: debounced channel B level; feeds gate input `b`.
- `a_rise` output 1: one-cycle pulse when `a` goes 0→1.
- `b_rise` output 1: one-cycle pulse when `b` goes 0→1.

## Operation

Each channel is identical and independent. No logic is shared between channels other than `clk` and `rst`.

- **Synchronizer:** two flops, `s1 <= raw` and `s2 <= s1`.
  - Only `s2` is used downstream.
  - `raw` never reaches any other logic.
- **Per-channel state:**
  - `q` drives the `a`/`b` output.
  - `cnt[CNT_W-1:0]`.
  - One implicit two-state FSM:
    - STABLE when `s2 == q`.
    - PENDING when `s2 != q`.
- **STABLE:** `cnt <= 0`; `q` holds its value.
- **PENDING with `cnt < STABLE_CYCLES-1`:** `cnt <= cnt + 1`; `q` holds its value.
- **PENDING with `cnt == STABLE_CYCLES-1`:** `q <= s2` and `cnt <= 0`, returning to STABLE.
- **Glitch rejection:** if `s2` returns to `q` before the terminal count, `cnt` clears. A later disagreement restarts counting from 0; there is no partial credit.
- **Counter wrap:** `cnt` never exceeds `STABLE_CYCLES-1`, so it cannot wrap.
- **`STABLE_CYCLES == 1`:** `q` follows `s2` one cycle later, i.e. a synchronizer plus one register.
- **Rise pulse:** `a_rise`/`b_rise` are registered and asserted exactly in the first cycle that `q` reads 1. They are never asserted for 1→0 transitions.
- **Reset:** `rst` high clears `s1`, `s2`, `q`, `cnt` and the rise pulses to 0 immediately, independent of `clk`.
  - Reset mid-count discards the pending transition.
  - After release, a raw input held at 1 produces `a=1` a full latency later, together with an `a_rise` pulse.

## Timing

- **Reset values:** `a=0`, `b=0`, `a_rise=0`, `b_rise=0`.
- **Latency:**
  - A raw level that meets setup at edge E0 and stays stable appears on `q` after edge E(STABLE_CYCLES+1).
  - Example: `STABLE_CYCLES=4` gives an update at edge 5.
- **Rejection threshold:**
  - A synchronized pulse shorter than `STABLE_CYCLES` cycles is never propagated.
  - A pulse of exactly `STABLE_CYCLES` cycles is propagated.
- **Rise pulses:**
  - Width is exactly 1 cycle.
  - Two rises on the same channel are at least 2·`STABLE_CYCLES` cycles apart, because a fall must also debounce in between.
- **Simultaneous events:**
  - Both channels may flip on the same edge.
  - `a_rise` and `b_rise` may assert together.
- **Async inputs:** metastability is confined to `s1`.

## Configuration

- **`DEBOUNCE_RISE_EN` defined:** rise-pulse logic is compiled in and behaves as described above.
- **`DEBOUNCE_RISE_EN` undefined:**
  - `a_rise` and `b_rise` remain as ports, so the interface is unchanged.
  - Both are tied to constant 0, and their registers are not generated.
  - `a`/`b` behaviour is identical in both builds.

## Test plan

All scenarios use `STABLE_CYCLES=4`.

- **Reset:** assert `rst` mid-simulation with `a_raw=b_raw=1` and `q=1` → `a=b=0` and `a_rise=b_rise=0` immediately, before the next `clk` edge.
- **Clean rise:**
  - Stimulus: `a_raw` 0→1 sampled at edge 0, then held.
  - Required: `a=1` after edge 5.
  - Required: `a_rise=1` for exactly the cycle following edge 5, and 0 thereafter.
  - Required: `b` is unaffected.
- **Glitch reject:** `a_raw` high for 3 synchronized cycles, then low → `a` stays 0 and `a_rise` never asserts. Repeat with 4 cycles high → `a=1` for at least one cycle, then `a` returns to 0 five edges after the fall is sampled.
- **Bounce restart:**
  - Stimulus: `b_raw` pattern 1,1,0,1,1,1,1 on consecutive edges.
  - Required: `b` rises only after the final run of four 1s has been seen at `s2`, not earlier.
- **Simultaneous:** `a_raw` and `b_raw` rise on the same edge → `a` and `b` rise on the same edge, and `a_rise` and `b_rise` pulse together.
- **Config:** rebuild without `DEBOUNCE_RISE_EN` and rerun the clean-rise scenario → `a` timing is unchanged and `a_rise` stays 0 throughout.
